// File: rtl/alu4_reg.sv
// -----------------------------------------------------------------------------
// alu4_reg
//
// Registered 4-bit ALU with NZCV condition flags, used as the execute stage of
// a small 4-bit datapath. One of eight operations is computed combinationally
// from a, b and op. The result and its flags are captured on every rising clock
// edge, which gives a latency of one cycle and a throughput of one operation
// per cycle.
//
// Ports:
//   clk     in   1  clock; all state updates on the rising edge
//   rst     in   1  asynchronous, active-high reset; clears all outputs
//   a       in   4  operand A
//   b       in   4  operand B
//   op      in   3  operation select (see op_e)
//   result  out  4  registered result
//   c       out  1  registered carry (for subtract: 1 = no borrow)
//   n       out  1  registered negative flag (result[3])
//   z       out  1  registered zero flag
//   v       out  1  registered signed-overflow flag
// -----------------------------------------------------------------------------
module alu4_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       c,
    output logic       n,
    output logic       z,
    output logic       v
);

    typedef enum logic [2:0] {
        OP_NOT_A = 3'b000,
        OP_NOT_B = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_ADD   = 3'b110,
        OP_SUB   = 3'b111
    } op_e;

    op_e op_sel;
    assign op_sel = op_e'(op);

    // One adder serves both add and subtract. Subtract is a + ~b + 1, so the
    // carry out reads as "no borrow".
    logic       is_sub;
    logic [3:0] b_eff;
    logic [4:0] sum;

    assign is_sub = (op_sel == OP_SUB);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {4'b0000, is_sub};

    logic [3:0] r_next;
    logic       c_next;
    logic       v_next;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        r_next = 4'b0000;
        c_next = 1'b0;
        v_next = 1'b0;
        case (op_sel)
            OP_NOT_A: r_next = ~a;
            OP_NOT_B: r_next = ~b;
            OP_AND:   r_next = a & b;
            OP_OR:    r_next = a | b;
            OP_XOR:   r_next = a ^ b;
            OP_XNOR:  r_next = ~(a ^ b);
            OP_ADD, OP_SUB: begin
                r_next = sum[3:0];
                c_next = sum[4];
                // Overflow when both adder inputs share a sign that the sum
                // does not. Using b_eff covers add and subtract with one term.
                v_next = (a[3] == b_eff[3]) && (sum[3] != a[3]);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments, so every
        // register samples the values from before this edge.
        if (rst) begin
            // z is cleared as well, on purpose. It is not derived from the
            // zeroed result.
            result <= 4'b0000;
            c      <= 1'b0;
            n      <= 1'b0;
            z      <= 1'b0;
            v      <= 1'b0;
        end else begin
            result <= r_next;
            c      <= c_next;
            n      <= r_next[3];
            z      <= (r_next == 4'b0000);
            v      <= v_next;
        end
    end

endmodule

// File: tb/tb_alu4_reg.sv
// -----------------------------------------------------------------------------
// tb_alu4_reg
//
// Self-checking bench for alu4_reg. It runs directed vectors with expected
// values written out by hand, then random operations that are compared against
// an integer-arithmetic reference model. It also covers asynchronous reset,
// holding outputs between edges, and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_alu4_reg;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] result;
    logic       c;
    logic       n;
    logic       z;
    logic       v;

    int n_checks = 0;
    int n_fail   = 0;

    alu4_reg dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result),
        .c      (c),
        .n      (n),
        .z      (z),
        .v      (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] r;
        logic [3:0] f;   // {n, z, c, v}
    } vec_t;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference model: the operations computed as plain integer arithmetic.
    function automatic void model(input logic [3:0] ma, input logic [3:0] mb,
                                  input logic [2:0] mop,
                                  output logic [3:0] r, output logic [3:0] f);
        int ua, ub, sa, sb, s, ss;
        logic cc, vv;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        cc = 1'b0;
        vv = 1'b0;
        case (mop)
            3'd0: r = ~ma;
            3'd1: r = ~mb;
            3'd2: r = ma & mb;
            3'd3: r = ma | mb;
            3'd4: r = ma ^ mb;
            3'd5: r = ~(ma ^ mb);
            3'd6: begin
                s  = ua + ub;
                r  = 4'(s % 16);
                cc = (s > 15);
                ss = sa + sb;
                vv = (ss > 7) || (ss < -8);
            end
            default: begin
                s  = ua - ub;
                r  = 4'((s + 16) % 16);
                cc = (ua >= ub);
                ss = sa - sb;
                vv = (ss > 7) || (ss < -8);
            end
        endcase
        f = {r[3], (r == 4'd0), cc, vv};
    endfunction

    // Apply inputs, take one rising edge, and check the registered outputs
    // 1 time unit after the edge.
    task automatic step(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic [2:0] top, input logic [3:0] er, input logic [3:0] ef);
        a  = ta;
        b  = tb_v;
        op = top;
        @(posedge clk);
        #1;
        check({tag, "_result"}, result, er);
        check({tag, "_nzcv"}, {n, z, c, v}, ef);
    endtask

    vec_t       dir [17];
    logic [3:0] er, ef, hold_r, hold_f;

    initial begin
        dir = '{
            '{4'h0, 4'h0, 3'd0, 4'hF, 4'b1000},
            '{4'hC, 4'h0, 3'd0, 4'h3, 4'b0000},
            '{4'hC, 4'h3, 3'd1, 4'hC, 4'b1000},
            '{4'h5, 4'h9, 3'd2, 4'h1, 4'b0000},
            '{4'h5, 4'hA, 3'd3, 4'hF, 4'b1000},
            '{4'h3, 4'h5, 3'd4, 4'h6, 4'b0000},
            '{4'h3, 4'h5, 3'd5, 4'h9, 4'b1000},
            '{4'h0, 4'h0, 3'd6, 4'h0, 4'b0100},
            '{4'hF, 4'hF, 3'd6, 4'hE, 4'b1010},
            '{4'hA, 4'h3, 3'd6, 4'hD, 4'b1000},
            '{4'h1, 4'h8, 3'd6, 4'h9, 4'b1000},
            '{4'h7, 4'h7, 3'd6, 4'hE, 4'b1001},
            '{4'h3, 4'h3, 3'd6, 4'h6, 4'b0000},
            '{4'hF, 4'h5, 3'd7, 4'hA, 4'b1010},
            '{4'h5, 4'h7, 3'd7, 4'hE, 4'b1000},
            '{4'hA, 4'hA, 3'd7, 4'h0, 4'b0110},
            '{4'h7, 4'h9, 3'd7, 4'hE, 4'b1001}
        };

        // Reset is asserted at time 0, and the outputs must clear without a clock edge.
        rst = 1'b1;
        a   = 4'h5;
        b   = 4'h5;
        op  = 3'd6;
        #1;
        check("reset_result", result, 4'h0);
        check("reset_nzcv", {n, z, c, v}, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_held_nzcv", {n, z, c, v}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors. Consecutive steps also exercise back-to-back ops.
        foreach (dir[i])
            step($sformatf("dir%0d", i), dir[i].a, dir[i].b, dir[i].op, dir[i].r, dir[i].f);

        // Inputs that change between edges must not disturb the outputs.
        hold_r = dir[16].r;
        hold_f = dir[16].f;
        a  = 4'h3;
        b  = 4'h1;
        op = 3'd0;
        #3;
        check("hold_result", result, hold_r);
        check("hold_nzcv", {n, z, c, v}, hold_f);
        model(4'h3, 4'h1, 3'd0, er, ef);
        step("hold_next", 4'h3, 4'h1, 3'd0, er, ef);

        // A reset raised mid-stream clears at once and discards the in-flight op.
        a  = 4'h9;
        b  = 4'h9;
        op = 3'd6;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_result", result, 4'h0);
        check("midrst_nzcv", {n, z, c, v}, 4'b0000);
        @(posedge clk);
        #1;
        check("midrst_held", result, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        step("after_rst", 4'hF, 4'h5, 3'd7, 4'hA, 4'b1010);

        // Random operations checked against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ra, rb;
            logic [2:0] rop;
            ra  = 4'($urandom_range(15));
            rb  = 4'($urandom_range(15));
            rop = 3'($urandom_range(7));
            model(ra, rb, rop, er, ef);
            step($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), ra, rb, rop, er, ef);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
